// File: rtl/crumb_gen_if.sv
// crumb_gen cell bus: step handshake, rule masks,
// state shift chain and display scan chain.
interface crumb_gen_if #(
  parameter int NEIGH   = 8,
  parameter int STATE_W = 2
);
  logic               step;
  logic               shift_en;
  logic               disp_load;
  logic               disp_shift;
  logic [NEIGH:0]     birth_mask;
  logic [NEIGH:0]     survive_mask;
  logic [NEIGH-1:0]   neighbors;
  logic [STATE_W-1:0] shift_in;
  logic [STATE_W-1:0] shift_out;
  logic [STATE_W-1:0] state;
  logic               alive;
  logic               disp_in;
  logic               disp_out;
  logic               busy;
  logic               done;

  modport master (
    output step, shift_en, disp_load, disp_shift,
    output birth_mask, survive_mask, neighbors,
    output shift_in, disp_in,
    input  shift_out, state, alive,
    input  disp_out, busy, done
  );

  modport slave (
    input  step, shift_en, disp_load, disp_shift,
    input  birth_mask, survive_mask, neighbors,
    input  shift_in, disp_in,
    output shift_out, state, alive,
    output disp_out, busy, done
  );
endinterface

// File: rtl/crumb_gen.sv
// crumb_gen: one Generations-style automaton cell
// with two-cycle count/commit step and scan chains.
module crumb_gen #(
  parameter int NEIGH      = 8,
  parameter int STATE_W    = 2,
  parameter int NUM_STATES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  crumb_gen_if.slave  io
);
  localparam int CW = $clog2(NEIGH + 1);
  localparam logic [STATE_W:0] NS =
    (STATE_W + 1)'(NUM_STATES);
  localparam logic [STATE_W:0] LAST =
    NS - (STATE_W + 1)'(1);

  typedef enum logic {
    IDLE,
    COUNT
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] nxt;
  logic [STATE_W:0]   wide;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      pop;
  logic               disp_q, disp_d;
  logic               done_q, done_d;
  logic               alive;

  assign wide  = {1'b0, state_q};
  assign alive = (state_q == STATE_W'(1));

  // Live-neighbour popcount, registered at step accept.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NEIGH; i++) begin
      pop = pop + CW'(io.neighbors[i]);
    end
  end

  // Rule: birth/survive for 0/1, fixed decay above.
  always_comb begin
    nxt = '0;
    unique case (1'b1)
      (wide >= NS): nxt = '0;
      (state_q == STATE_W'(1)): begin
        if (io.survive_mask[cnt_q])
          nxt = STATE_W'(1);
        else if (NUM_STATES == 2)
          nxt = STATE_W'(0);
        else
          nxt = STATE_W'(2);
      end
      (state_q == STATE_W'(0)): begin
        nxt = io.birth_mask[cnt_q] ?
              STATE_W'(1) : STATE_W'(0);
      end
      default: begin
        nxt = (wide == LAST) ?
              STATE_W'(0) : state_q + STATE_W'(1);
      end
    endcase
  end

  // Prioritised next-state: pipeline > step > shift > disp.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    done_d  = done_q;
    if (en) begin
      done_d = 1'b0;
      if (fsm_q == COUNT) begin
        state_d = nxt;
        fsm_d   = IDLE;
        done_d  = 1'b1;
      end else if (io.step) begin
        cnt_d = pop;
        fsm_d = COUNT;
      end else if (io.shift_en) begin
        state_d = io.shift_in;
      end else if (io.disp_load) begin
        disp_d = alive;
      end else if (io.disp_shift) begin
        disp_d = io.disp_in;
      end
    end
  end

  // Single state register; reset abandons any step.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      disp_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
    end
  end

  assign io.state     = state_q;
  assign io.shift_out = state_q;
  assign io.alive     = alive;
  assign io.disp_out  = disp_q;
  assign io.busy      = (fsm_q == COUNT);
  assign io.done      = done_q;
endmodule

// File: tb/tb_crumb_gen.sv
// Scoreboard bench for crumb_gen: Life, decay,
// chain shift, step handshake, enable, reset, display.
module tb_crumb_gen;
  logic clk;
  logic rst;
  logic en_a;
  logic en_1;

  int tests;
  int fails;

  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] qc[$];

  crumb_gen_if #(.NEIGH(8), .STATE_W(2)) ia ();
  crumb_gen_if #(.NEIGH(8), .STATE_W(2)) ib ();
  crumb_gen_if #(.NEIGH(8), .STATE_W(2)) ic0 ();
  crumb_gen_if #(.NEIGH(8), .STATE_W(2)) ic1 ();
  crumb_gen_if #(.NEIGH(8), .STATE_W(2)) ic2 ();

  crumb_gen #(.NEIGH(8), .STATE_W(2), .NUM_STATES(2))
    ua (.clk(clk), .rst(rst), .en(en_a), .io(ia.slave));
  crumb_gen #(.NEIGH(8), .STATE_W(2), .NUM_STATES(4))
    ub (.clk(clk), .rst(rst), .en(en_1), .io(ib.slave));
  crumb_gen #(.NEIGH(8), .STATE_W(2), .NUM_STATES(3))
    uc0 (.clk(clk), .rst(rst), .en(en_1), .io(ic0.slave));
  crumb_gen #(.NEIGH(8), .STATE_W(2), .NUM_STATES(3))
    uc1 (.clk(clk), .rst(rst), .en(en_1), .io(ic1.slave));
  crumb_gen #(.NEIGH(8), .STATE_W(2), .NUM_STATES(3))
    uc2 (.clk(clk), .rst(rst), .en(en_1), .io(ic2.slave));

  assign ic1.shift_in = ic0.shift_out;
  assign ic2.shift_in = ic1.shift_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: each done pulse pops one expected state.
  always @(posedge clk) begin
    #1;
    if (ia.done === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
      else chk("a_commit", 32'(ia.state), 32'(qa.pop_front()));
    end
  end

  always @(posedge clk) begin
    #1;
    if (ib.done === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
      else chk("b_commit", 32'(ib.state), 32'(qb.pop_front()));
    end
  end

  always @(posedge clk) begin
    #1;
    if (ic0.done === 1'b1) begin
      if (qc.size() == 0) chk("c_unexpected_done", 1, 0);
      else chk("c_commit", 32'(ic0.state), 32'(qc.pop_front()));
    end
  end

  task automatic do_step(input int w, input logic [7:0] nb);
    case (w)
      0: begin ia.neighbors = nb; ia.step = 1'b1; end
      1: begin ib.neighbors = nb; ib.step = 1'b1; end
      default: begin ic0.neighbors = nb; ic0.step = 1'b1; end
    endcase
    tick();
    ia.step  = 1'b0;
    ib.step  = 1'b0;
    ic0.step = 1'b0;
    case (w)
      0: chk("a_busy", 32'(ia.busy), 1);
      1: chk("b_busy", 32'(ib.busy), 1);
      default: chk("c_busy", 32'(ic0.busy), 1);
    endcase
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    en_a  = 1'b1;
    en_1  = 1'b1;
    ia.step = 0; ia.shift_en = 0; ia.disp_load = 0;
    ia.disp_shift = 0; ia.disp_in = 0; ia.shift_in = 0;
    ia.neighbors = 0;
    ia.birth_mask = 9'b0_0000_1000;
    ia.survive_mask = 9'b0_0000_1100;
    ib.step = 0; ib.shift_en = 0; ib.disp_load = 0;
    ib.disp_shift = 0; ib.disp_in = 0; ib.shift_in = 0;
    ib.neighbors = 0;
    ib.birth_mask = 9'b0_0000_1000;
    ib.survive_mask = 9'b0_0000_1100;
    ic0.step = 0; ic0.shift_en = 0; ic0.disp_load = 0;
    ic0.disp_shift = 0; ic0.disp_in = 0; ic0.shift_in = 0;
    ic0.neighbors = 0;
    ic0.birth_mask = 9'b0_0000_1000;
    ic0.survive_mask = 9'b0_0000_1100;
    ic1.step = 0; ic1.shift_en = 0; ic1.disp_load = 0;
    ic1.disp_shift = 0; ic1.disp_in = 0; ic1.neighbors = 0;
    ic1.birth_mask = 9'b0_0000_1000;
    ic1.survive_mask = 9'b0_0000_1100;
    ic2.step = 0; ic2.shift_en = 0; ic2.disp_load = 0;
    ic2.disp_shift = 0; ic2.disp_in = 0; ic2.neighbors = 0;
    ic2.birth_mask = 9'b0_0000_1000;
    ic2.survive_mask = 9'b0_0000_1100;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_state", 32'(ia.state), 0);
    chk("rst_shift_out", 32'(ia.shift_out), 0);
    chk("rst_alive", 32'(ia.alive), 0);
    chk("rst_disp_out", 32'(ia.disp_out), 0);
    chk("rst_busy", 32'(ia.busy), 0);
    chk("rst_done", 32'(ia.done), 0);
    chk("rst_b_state", 32'(ib.state), 0);

    // B3/S23: birth with 3, death with 1.
    qa.push_back(2'd1);
    do_step(0, 8'b0000_0111);
    chk("a_done_cleared", 32'(ia.done), 0);
    qa.push_back(2'd0);
    do_step(0, 8'b0000_0001);

    // step held two cycles: one commit only.
    ia.neighbors = 8'h07;
    ia.step = 1'b1;
    qa.push_back(2'd1);
    tick();
    tick();
    ia.step = 1'b0;
    chk("dbl_busy_low", 32'(ia.busy), 0);
    tick();
    chk("dbl_state", 32'(ia.state), 1);
    chk("dbl_no_second", 32'(ia.busy), 0);
    tick();

    // shift_en during COUNT is dropped.
    ia.neighbors = 8'h07;
    ia.step = 1'b1;
    qa.push_back(2'd1);
    tick();
    ia.step = 1'b0;
    ia.shift_en = 1'b1;
    ia.shift_in = 2'd0;
    tick();
    ia.shift_en = 1'b0;
    chk("busy_shift_state", 32'(ia.state), 1);
    tick();
    chk("busy_shift_hold", 32'(ia.state), 1);

    // en low mid-pipeline holds everything.
    ia.neighbors = 8'h00;
    ia.step = 1'b1;
    qa.push_back(2'd0);
    tick();
    ia.step = 1'b0;
    en_a = 1'b0;
    repeat (5) tick();
    chk("en_hold_busy", 32'(ia.busy), 1);
    chk("en_hold_state", 32'(ia.state), 1);
    chk("en_hold_done", 32'(ia.done), 0);
    en_a = 1'b1;
    tick();
    chk("en_commit_state", 32'(ia.state), 0);
    chk("en_commit_done", 32'(ia.done), 1);
    chk("en_commit_busy", 32'(ia.busy), 0);
    tick();

    // rst in COUNT abandons the step.
    ia.neighbors = 8'h07;
    ia.step = 1'b1;
    tick();
    ia.step = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_state", 32'(ia.state), 0);
    chk("rstmid_busy", 32'(ia.busy), 0);
    chk("rstmid_done", 32'(ia.done), 0);
    tick();
    chk("rstmid_done2", 32'(ia.done), 0);
    chk("rstmid_state2", 32'(ia.state), 0);

    // display chain: load alive, then shift 0,1.
    ia.shift_en = 1'b1;
    ia.shift_in = 2'd1;
    tick();
    ia.shift_en = 1'b0;
    chk("load_alive", 32'(ia.alive), 1);
    ia.disp_load = 1'b1;
    tick();
    ia.disp_load = 1'b0;
    chk("disp_load", 32'(ia.disp_out), 1);
    ia.disp_shift = 1'b1;
    ia.disp_in = 1'b0;
    tick();
    chk("disp_shift0", 32'(ia.disp_out), 0);
    ia.disp_in = 1'b1;
    tick();
    chk("disp_shift1", 32'(ia.disp_out), 1);
    ia.disp_shift = 1'b0;

    // Generations decay 1->2->3->0->0.
    ib.shift_en = 1'b1;
    ib.shift_in = 2'd1;
    tick();
    ib.shift_en = 1'b0;
    chk("b_loaded", 32'(ib.state), 1);
    qb.push_back(2'd2);
    do_step(1, 8'h00);
    qb.push_back(2'd3);
    do_step(1, 8'hFF);
    qb.push_back(2'd0);
    do_step(1, 8'hFF);
    qb.push_back(2'd0);
    do_step(1, 8'hFF);

    // 3-cell chain shift, then illegal state -> 0.
    ic0.shift_en = 1'b1;
    ic1.shift_en = 1'b1;
    ic2.shift_en = 1'b1;
    ic0.shift_in = 2'd1;
    tick();
    ic0.shift_in = 2'd2;
    tick();
    ic0.shift_in = 2'd3;
    tick();
    ic0.shift_en = 1'b0;
    ic1.shift_en = 1'b0;
    ic2.shift_en = 1'b0;
    chk("chain_c0", 32'(ic0.state), 3);
    chk("chain_c1", 32'(ic1.state), 2);
    chk("chain_c2", 32'(ic2.state), 1);
    qc.push_back(2'd0);
    do_step(2, 8'h00);
    chk("chain_c1_hold", 32'(ic1.state), 2);

    tick();
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    chk("qc_drained", 32'(qc.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/crumb_gen.md
# crumb_gen

Parametrised successor to the single-bit Life cell: one cellular-automaton cell with a run-time-programmable birth/survive rule, configurable neighbourhood size, and multi-state "Generations" decay. It sits as the tile in the cell array, daisy-chained for state load/readback and for display scan-out. Generation steps use a two-cycle count/commit pipeline with a busy/done handshake, so the whole array advances in lock-step.

## Interface
Parameters:
- NEIGH, 8: number of neighbour inputs (1..8).
- STATE_W, 2: cell state width in bits.
- NUM_STATES, 4: number of legal states, 2..2^STATE_W. 2 gives classic Life; >2 adds decay states.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when low, all registers hold.
- step  in  1  single-cycle request to compute one generation.
- shift_en  in  1  load/readback shift of the state chain.
- disp_load  in  1  capture own alive bit into display register.
- disp_shift  in  1  shift display chain.
- birth_mask  in  NEIGH+1  bit k set: dead cell with k live neighbours is born.
- survive_mask  in  NEIGH+1  bit k set: live cell with k live neighbours survives.
- neighbors  in  NEIGH  alive flags of neighbouring cells.
- shift_in  in  STATE_W  state from upstream cell.
- shift_out  out  STATE_W  current state, combinational from state register, to downstream cell.
- state  out  STATE_W  current cell state.
- alive  out  1  state == 1 (combinational).
- disp_in  in  1  display chain input.
- disp_out  out  1  display chain output, registered.
- busy  out  1  step pipeline occupied.
- done  out  1  one-cycle pulse after a generation commits.

## Operation
- State encoding: 0 dead, 1 alive, 2..NUM_STATES-1 decaying (count as not alive for neighbours).
- Live count: popcount(neighbors), width clog2(NEIGH+1); indexes masks directly, no saturation needed.
- Next-state rule on commit:
  - state 1: survive_mask[cnt] ? 1 : (NUM_STATES==2 ? 0 : 2).
  - state 0: birth_mask[cnt] ? 1 : 0.
  - state k in 2..NUM_STATES-1: k==NUM_STATES-1 ? 0 : k+1 (neighbours ignored).
  - illegal state (>= NUM_STATES, only via shift_in): commits to 0.
- FSM: IDLE -> COUNT -> IDLE.
  - IDLE: step accepted; neighbors popcount registered; go COUNT, busy=1.
  - COUNT: next state computed from registered count and committed; done pulses next cycle; back to IDLE.
- Priority when en=1: rst > active step pipeline > step accept > shift_en > disp_load > disp_shift. Lower-priority requests in the same cycle are dropped, not queued.
- step while busy: ignored. shift_en/disp_* while busy: ignored.
- Shift: state <= shift_in; shift_in values loaded verbatim (one cell per cycle along the chain).
- Display: disp_load: disp_out <= alive; disp_shift: disp_out <= disp_in.
- en=0: everything holds including FSM; a pending COUNT completes when en returns; done stays low until then.

## Timing
- Reset values: state 0, shift_out 0, alive 0, disp_out 0, busy 0, done 0, internal count 0, FSM IDLE.
- step accepted at edge T: busy=1 during T..T+1; new state visible after edge T+1; done=1 and busy=0 for the cycle after T+1; next step acceptable at edge T+2 (one generation per 2 cycles).
- neighbors sampled only at the accepting edge; array cells all sample pre-commit values since commits occur one edge later.
- Shift and display ops: 1-cycle latency.
- rst mid-pipeline: abandons step, no commit, no done pulse.

## Test plan
- B3/S23, NUM_STATES=2: dead cell, neighbors=8'b0000_0111, step -> state 1 two edges later, done pulses once; alive cell with 1 neighbour -> 0.
- NUM_STATES=4: alive cell, 0 neighbours, four steps -> state sequence 2,3,0,0; decay ignores neighbors=8'hFF.
- Chain of 3 cells, shift_en 3 cycles with shift_in 1,2,3 -> cell states 3,2,1; shift_in 3 with NUM_STATES=3 then step -> 0.
- step asserted on two consecutive cycles -> only one commit, one done; shift_en during busy -> state unchanged by shift.
- en low between accept and commit for 5 cycles -> state/busy held, commit and done follow re-enable by 1 edge.
- rst asserted in COUNT cycle -> all outputs 0 next cycle, no done; disp_load on alive cell then 2 disp_shift with disp_in=0,1 -> disp_out 1,0,1.
